ym3438_timers: RTL and testbench

YM3438_TIMERS -- requirements
Module: ym3438_timers

---
 rtl/ym3438_pkg.sv | 25 ++
 rtl/ym3438_timer_cnt.sv | 40 ++++
 rtl/ym3438_timers.sv | 106 ++++++++++
 tb/tb_ym3438_timers.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ym3438_pkg.sv
// Shared constants for the YM3438 timer block: default widths, reg 0x27 bit
// positions and the channel-3 mode encoding.
package ym3438_pkg;

  localparam int TA_W_DEF   = 10;
  localparam int TB_W_DEF   = 8;
  localparam int TB_PRE_DEF = 16;

  localparam int R27_LOAD_A  = 0;
  localparam int R27_LOAD_B  = 1;
  localparam int R27_EN_A    = 2;
  localparam int R27_EN_B    = 3;
  localparam int R27_RST_A   = 4;
  localparam int R27_RST_B   = 5;
  localparam int R27_MODE_LO = 6;
  localparam int R27_MODE_HI = 7;

  typedef enum logic [1:0] {
    CH3_NORMAL = 2'b00,
    CH3_SPEC   = 2'b01,
    CH3_CSM    = 2'b10,
    CH3_SPEC2  = 2'b11
  } ch3_mode_e;

endpackage

// File: rtl/ym3438_timer_cnt.sv
// Up-counting timer with preset reload and a sticky status flag. All inputs
// are expected already qualified by the c1 phase enable.
module ym3438_timer_cnt #(
  parameter int W = 8
) (
  input  logic         MCLK,
  input  logic         IC,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] preset,
  input  logic         en,
  input  logic         clr,
  output logic         ovf,
  output logic         flag
);

  logic [W-1:0] cnt;

  // A load edge in the same cycle suppresses the overflow entirely.
  assign ovf = step & ~load & (&cnt);

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else begin
      if (load)
        cnt <= preset;
      else if (step)
        cnt <= ovf ? preset : cnt + W'(1);

      // Setting on overflow wins over the reset strobe.
      if (ovf && en)
        flag <= 1'b1;
      else if (clr)
        flag <= 1'b0;
    end
  end

endmodule

// File: rtl/ym3438_timers.sv
// YM3438 timer A / timer B block: reg 0x27 control latch, timer B prescaler,
// status flags, IRQ and CSM key-on generation.
module ym3438_timers
  import ym3438_pkg::*;
#(
  parameter int TA_W   = TA_W_DEF,
  parameter int TB_W   = TB_W_DEF,
  parameter int TB_PRE = TB_PRE_DEF
) (
  input  logic            MCLK,
  input  logic            IC,
  input  logic            c1,
  input  logic            timer_ed,
  input  logic [TA_W-1:0] reg_ta,
  input  logic [TB_W-1:0] reg_tb,
  input  logic            reg27_wr,
  input  logic [7:0]      reg27,
  output logic            timer_a,
  output logic            timer_b,
  output logic            irq,
  output logic            csm_kon,
  output logic [1:0]      ch3_mode
);

  localparam int PRE_W = (TB_PRE > 1) ? $clog2(TB_PRE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TB_PRE - 1);

  logic             load_a_q, load_b_q, en_a_q, en_b_q;
  logic [1:0]       mode_q;
  logic [PRE_W-1:0] pre;

  logic tick, wr;
  logic load_a_edge, load_b_edge;
  logic step_a, step_b;
  logic ovf_a, ovf_b;

  assign tick = c1 & timer_ed;
  assign wr   = c1 & reg27_wr;

  assign load_a_edge = wr & reg27[R27_LOAD_A] & ~load_a_q;
  assign load_b_edge = wr & reg27[R27_LOAD_B] & ~load_b_q;

  assign step_a = tick & load_a_q;
  assign step_b = tick & load_b_q & (pre == PRE_MAX);

  // Control latch; the reset bits are one-shot strobes and are not stored.
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      load_a_q <= 1'b0;
      load_b_q <= 1'b0;
      en_a_q   <= 1'b0;
      en_b_q   <= 1'b0;
      mode_q   <= 2'b00;
    end else if (wr) begin
      load_a_q <= reg27[R27_LOAD_A];
      load_b_q <= reg27[R27_LOAD_B];
      en_a_q   <= reg27[R27_EN_A];
      en_b_q   <= reg27[R27_EN_B];
      mode_q   <= reg27[R27_MODE_HI:R27_MODE_LO];
    end
  end

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC)
      pre <= '0;
    else if (load_b_edge)
      pre <= '0;
    else if (tick && load_b_q)
      pre <= (pre == PRE_MAX) ? '0 : pre + PRE_W'(1);
  end

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC)
      csm_kon <= 1'b0;
    else if (c1)
      csm_kon <= ovf_a & (mode_q == CH3_CSM);
  end

  ym3438_timer_cnt #(.W(TA_W)) u_timer_a (
    .MCLK   (MCLK),
    .IC     (IC),
    .step   (step_a),
    .load   (load_a_edge),
    .preset (reg_ta),
    .en     (en_a_q),
    .clr    (wr & reg27[R27_RST_A]),
    .ovf    (ovf_a),
    .flag   (timer_a)
  );

  ym3438_timer_cnt #(.W(TB_W)) u_timer_b (
    .MCLK   (MCLK),
    .IC     (IC),
    .step   (step_b),
    .load   (load_b_edge),
    .preset (reg_tb),
    .en     (en_b_q),
    .clr    (wr & reg27[R27_RST_B]),
    .ovf    (ovf_b),
    .flag   (timer_b)
  );

  assign irq      = timer_a | timer_b;
  assign ch3_mode = mode_q;

endmodule

// File: tb/tb_ym3438_timers.sv
// Directed bench for ym3438_timers: a vector table for timer A / CSM behaviour
// plus hand-written sequences for timer B periods, reset abort and load hold.
module tb_ym3438_timers;

  logic        MCLK = 1'b0;
  logic        IC = 1'b0;
  logic        c1 = 1'b0;
  logic        timer_ed = 1'b0;
  logic [9:0]  reg_ta = '0;
  logic [7:0]  reg_tb = '0;
  logic        reg27_wr = 1'b0;
  logic [7:0]  reg27 = '0;
  logic        timer_a, timer_b, irq, csm_kon;
  logic [1:0]  ch3_mode;

  int checks = 0;
  int errors = 0;

  always #5 MCLK = ~MCLK;

  ym3438_timers dut (
    .MCLK     (MCLK),
    .IC       (IC),
    .c1       (c1),
    .timer_ed (timer_ed),
    .reg_ta   (reg_ta),
    .reg_tb   (reg_tb),
    .reg27_wr (reg27_wr),
    .reg27    (reg27),
    .timer_a  (timer_a),
    .timer_b  (timer_b),
    .irq      (irq),
    .csm_kon  (csm_kon),
    .ch3_mode (ch3_mode)
  );

  typedef struct {
    logic [9:0] ta;
    logic [7:0] tb;
    logic       ed;
    logic       wr;
    logic [7:0] d;
    logic       a;
    logic       b;
    logic       irq;
    logic       kon;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic ed, input logic w, input logic [7:0] d);
    @(negedge MCLK);
    c1       = c;
    timer_ed = ed;
    reg27_wr = w;
    reg27    = d;
    @(posedge MCLK);
    #1;
  endtask

  // One c1 phase, then an idle phase with c1=0 carrying a hostile write/tick
  // that must be ignored. Outputs are valid when this task returns.
  task automatic phase(input logic ed, input logic w, input logic [7:0] d);
    cyc(1'b1, ed, w, d);
    cyc(1'b0, 1'b1, 1'b1, 8'h30);
    c1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge MCLK);
    IC = 1'b0;
    c1 = 1'b0;
    timer_ed = 1'b0;
    reg27_wr = 1'b0;
    repeat (2) @(negedge MCLK);
    IC = 1'b1;
  endtask

  task automatic count_until_a(input int bound, output int n);
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      phase(1'b1, 1'b0, 8'h00);
      if (timer_a && n == 0) n = i;
    end
  endtask

  task automatic count_until_b(input int bound, output int n);
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      phase(1'b1, 1'b0, 8'h00);
      if (timer_b && n == 0) n = i;
    end
  endtask

  initial begin
    int n;

    //            ta     tb     ed wr  d      a  b  irq kon
    vecs[0]  = '{10'd1020, 8'd255, 0, 1, 8'h05, 0, 0, 0, 0};
    vecs[1]  = '{10'd1020, 8'd255, 1, 0, 8'h00, 0, 0, 0, 0};
    vecs[2]  = '{10'd1020, 8'd255, 1, 0, 8'h00, 0, 0, 0, 0};
    vecs[3]  = '{10'd1020, 8'd255, 1, 0, 8'h00, 0, 0, 0, 0};
    vecs[4]  = '{10'd1020, 8'd255, 1, 0, 8'h00, 1, 0, 1, 0};
    vecs[5]  = '{10'd1020, 8'd255, 0, 1, 8'h15, 0, 0, 0, 0};
    vecs[6]  = '{10'd1020, 8'd255, 1, 0, 8'h00, 0, 0, 0, 0};
    vecs[7]  = '{10'd1020, 8'd255, 1, 0, 8'h00, 0, 0, 0, 0};
    vecs[8]  = '{10'd1020, 8'd255, 1, 0, 8'h00, 0, 0, 0, 0};
    vecs[9]  = '{10'd1020, 8'd255, 1, 1, 8'h15, 1, 0, 1, 0};
    vecs[10] = '{10'd1020, 8'd255, 0, 1, 8'h15, 0, 0, 0, 0};
    vecs[11] = '{10'd1023, 8'd255, 0, 1, 8'h04, 0, 0, 0, 0};
    vecs[12] = '{10'd1023, 8'd255, 0, 1, 8'h81, 0, 0, 0, 0};
    vecs[13] = '{10'd1023, 8'd255, 1, 0, 8'h00, 0, 0, 0, 1};
    vecs[14] = '{10'd1023, 8'd255, 1, 0, 8'h00, 0, 0, 0, 1};
    vecs[15] = '{10'd1023, 8'd255, 0, 0, 8'h00, 0, 0, 0, 0};
    vecs[16] = '{10'd1023, 8'd255, 1, 0, 8'h00, 0, 0, 0, 1};

    do_reset();
    #1;
    chk("reset_timer_a", timer_a, 0);
    chk("reset_timer_b", timer_b, 0);
    chk("reset_irq", irq, 0);
    chk("reset_csm_kon", csm_kon, 0);
    chk("reset_ch3_mode", ch3_mode, 0);

    for (int i = 0; i < 17; i++) begin
      reg_ta = vecs[i].ta;
      reg_tb = vecs[i].tb;
      phase(vecs[i].ed, vecs[i].wr, vecs[i].d);
      chk($sformatf("vec%0d_timer_a", i), timer_a, vecs[i].a);
      chk($sformatf("vec%0d_timer_b", i), timer_b, vecs[i].b);
      chk($sformatf("vec%0d_irq", i), irq, vecs[i].irq);
      chk($sformatf("vec%0d_csm_kon", i), csm_kon, vecs[i].kon);
    end
    chk("csm_ch3_mode", ch3_mode, 2);

    // Timer B period with preset 255 and 254
    do_reset();
    reg_tb = 8'd255;
    phase(1'b0, 1'b1, 8'h0A);
    count_until_b(40, n);
    chk("tb255_ticks", n, 16);
    do_reset();
    reg_tb = 8'd254;
    phase(1'b0, 1'b1, 8'h0A);
    count_until_b(60, n);
    chk("tb254_ticks", n, 32);

    // Asynchronous reset with both flags set, then no activity until reload
    do_reset();
    reg_ta = 10'd1020;
    reg_tb = 8'd255;
    phase(1'b0, 1'b1, 8'hCF);
    repeat (16) phase(1'b1, 1'b0, 8'h00);
    chk("pre_ic_timer_a", timer_a, 1);
    chk("pre_ic_timer_b", timer_b, 1);
    chk("pre_ic_ch3_mode", ch3_mode, 3);
    @(posedge MCLK);
    #3;
    IC = 1'b0;
    #1;
    chk("ic_async_timer_a", timer_a, 0);
    chk("ic_async_timer_b", timer_b, 0);
    chk("ic_async_irq", irq, 0);
    chk("ic_async_csm_kon", csm_kon, 0);
    chk("ic_async_ch3_mode", ch3_mode, 0);
    @(negedge MCLK);
    IC = 1'b1;
    count_until_a(40, n);
    chk("post_ic_no_ovf_a", n, 0);
    chk("post_ic_no_ovf_b", timer_b, 0);
    phase(1'b0, 1'b1, 8'h05);
    count_until_a(10, n);
    chk("post_ic_reload_ticks", n, 4);

    // Load A held low freezes the count; rising edge reloads the preset
    do_reset();
    reg_ta = 10'd1000;
    phase(1'b0, 1'b1, 8'h05);
    repeat (2) phase(1'b1, 1'b0, 8'h00);
    phase(1'b0, 1'b1, 8'h04);
    repeat (10) phase(1'b1, 1'b0, 8'h00);
    chk("hold_no_flag", timer_a, 0);
    phase(1'b0, 1'b1, 8'h05);
    count_until_a(40, n);
    chk("reload_1000_ticks", n, 24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
